// File: rtl/pp_reduce_pkg.sv
// Shared sizing helpers for the partial-product reduction pipeline.
// These are constant functions evaluated at elaboration time.
package pp_reduce_pkg;

   // Each 3:2 layer turns every group of three rows into two; leftovers pass through.
   function automatic int rows_after(input int n, input int lvl);
      int r;
      r = n;
      for (int i = 0; i < lvl; i++) begin
         if (r > 2) r = 2 * (r / 3) + r % 3;
      end
      return r;
   endfunction

   function automatic int csa_levels(input int n);
      int r;
      int l;
      r = n;
      l = 0;
      while (r > 2) begin
         r = 2 * (r / 3) + r % 3;
         l++;
      end
      return l;
   endfunction

   function automatic int cw_of(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational W-bit 3:2 compressor: sum row and carry row shifted up one bit.
// The carry out of the MSB is dropped, so the result is exact modulo 2^W.
module csa_row #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] cy
);

   logic [W-1:0] co;

   for (genvar i = 0; i < W; i++) begin : g_bit
      fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (co[i])
      );
   end

   assign cy = {co[W-2:0], 1'b0};

   logic unused_msb;
   assign unused_msb = co[W-1];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell used to build the 3:2 compressor rows.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/pp_reduce_pipe.sv
// Pipelined partial-product reduction: registered 3:2 layers, then a registered final add.
// Optional macro PP_REDUCE_CARRY_OUT_EN adds sum_hi so {sum_hi,sum} is the exact total.
module pp_reduce_pipe
   import pp_reduce_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NUM_PP = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_PP*WIDTH-1:0]  pp_flat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         sum
`ifdef PP_REDUCE_CARRY_OUT_EN
   ,
   output logic [cw_of(NUM_PP)-1:0] sum_hi
`endif
);

   localparam int L = csa_levels(NUM_PP);
`ifdef PP_REDUCE_CARRY_OUT_EN
   localparam int CW = cw_of(NUM_PP);
   localparam int RW = WIDTH + CW;
`else
   localparam int RW = WIDTH;
`endif
   localparam int FW = NUM_PP * RW;

   // Valid/ready: a transfer happens on in_valid & in_ready; the whole pipe freezes
   // while the output holds a result that downstream has not taken.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // chain[l] is the row set entering layer l; unused upper rows are zero.
   logic [FW-1:0] chain  [L+1];
   logic          vchain [L+1];
   logic [FW-1:0] chain0;

   always_comb begin
      chain0 = '0;
      for (int k = 0; k < NUM_PP; k++) begin
         chain0[k*RW +: RW] = RW'(pp_flat[k*WIDTH +: WIDTH]);
      end
   end

   assign chain[0]  = chain0;
   assign vchain[0] = in_valid & in_ready;

   for (genvar l = 0; l < L; l++) begin : g_lvl
      localparam int N  = rows_after(NUM_PP, l);
      localparam int NG = N / 3;
      localparam int NL = N % 3;
      localparam int NO = 2 * NG + NL;

      logic [RW-1:0]    s_arr [NG];
      logic [RW-1:0]    c_arr [NG];
      logic [NO*RW-1:0] nxt;
      logic [NO*RW-1:0] rows_q;
      logic             vld_q;

      for (genvar g = 0; g < NG; g++) begin : g_csa
         csa_row #(.W(RW)) u_csa (
            .a  (chain[l][(3*g)*RW +: RW]),
            .b  (chain[l][(3*g+1)*RW +: RW]),
            .c  (chain[l][(3*g+2)*RW +: RW]),
            .s  (s_arr[g]),
            .cy (c_arr[g])
         );
      end

      always_comb begin
         nxt = '0;
         for (int g = 0; g < NG; g++) begin
            nxt[(2*g)*RW +: RW]   = s_arr[g];
            nxt[(2*g+1)*RW +: RW] = c_arr[g];
         end
         for (int j = 0; j < NL; j++) begin
            nxt[(2*NG+j)*RW +: RW] = chain[l][(3*NG+j)*RW +: RW];
         end
      end

      // Row data is don't-care while its valid bit is low, so it needs no reset.
      always_ff @(posedge clk) begin
         if (!stall) rows_q <= nxt;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
         end else if (!stall) begin
            vld_q <= vchain[l];
         end
      end

      assign chain[l+1]  = FW'(rows_q);
      assign vchain[l+1] = vld_q;
   end

   logic [RW-1:0] total;
   assign total = chain[L][0 +: RW] + chain[L][RW +: RW];

   logic unused_rows;
   assign unused_rows = ^chain[L][FW-1:2*RW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
`ifdef PP_REDUCE_CARRY_OUT_EN
         sum_hi    <= '0;
`endif
      end else if (!stall) begin
         out_valid <= vchain[L];
         sum       <= total[WIDTH-1:0];
`ifdef PP_REDUCE_CARRY_OUT_EN
         sum_hi    <= total[RW-1:WIDTH];
`endif
      end
   end

endmodule

// File: doc/pp_reduce_pipe.md
Name: pp_reduce_pipe

Overview:
Pipelined, parametrised partial-product reduction tree for the radix-4 Booth multiplier datapath. It generalises the fixed 4x16-bit carry-save adder to NUM_PP rows of WIDTH bits. The block reduces the rows with registered layers of 3:2 compressors, then applies a registered final carry-propagate add. A valid/ready handshake with global stall sits between the Booth encoder/PP generator and the product register.

Parameters:
WIDTH, 16, bit width of each partial product and of sum (legal 4..64)
NUM_PP, 4, number of partial-product rows (legal 3..9)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pp_flat holds a valid operand set
in_ready  out  1  block accepts pp_flat this cycle
pp_flat  in  NUM_PP*WIDTH  row k at bits [k*WIDTH +: WIDTH]; row 0 in the LSBs
out_valid  out  1  sum is valid
out_ready  in  1  downstream accepts sum
sum  out  WIDTH  (sum of all rows) mod 2^WIDTH

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Pipeline structure:
  - L = csa_levels(NUM_PP) CSA stages, then 1 CPA stage; latency LAT = L+1 cycles from accept to out_valid.
  - csa_levels values: 3->1, 4->2, 5..6->3, 7..9->4.
  - Each CSA stage groups rows in threes from row 0. Each group gives s = a^b^c and c = maj(a,b,c)<<1; the carry MSB is dropped (modular).
  - Leftover rows (1 or 2) pass through unchanged. Rows emitted per stage = 2*floor(n/3) + n mod 3.
  - After L stages exactly 2 rows remain. The CPA stage registers row0+row1 truncated to WIDTH.
- Valid bits: each stage carries a valid bit. Data registers load on stall-free cycles only; contents of invalid stages are don't-care.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - A transfer occurs when in_valid & in_ready.
  - When stall=1, every stage holds data and valid.
  - When stall=0, every stage advances and stage0 valid takes in_valid & in_ready.
  - Bubbles are not collapsed.
  - Throughput is 1 result/cycle with out_ready held high.
- Output ordering: strictly in input order; no drops, no duplicates.
- Reset: all valid bits and sum clear to 0; out_valid=0.
  - in_ready is 1 during and after reset, since stall is 0.
  - Reset mid-operation discards all in-flight results; nothing from before reset appears afterwards.
- Boundary conditions:
  - out_ready low with an empty pipeline: no stall, and inputs keep filling until the output stage is valid.
  - in_valid dropped while stalled: no effect.
  - pp_flat and in_valid are sampled only on a transfer.
- Arithmetic: unsigned, modulo 2^WIDTH. Booth sign handling is the generator's job; two's-complement rows sum correctly mod 2^WIDTH.

Optional Feature:
Macro PP_REDUCE_CARRY_OUT_EN.
- Defined:
  - Adds output port sum_hi of width CW = clog2(NUM_PP), registered alongside sum.
  - All internal rows widen to WIDTH+CW, with inputs zero-extended.
  - {sum_hi,sum} is the exact unsigned sum of all rows.
  - sum_hi resets to 0 and holds during stall.
- Undefined: the sum_hi port is absent and internal rows stay WIDTH bits. sum is identical in both builds.

Decomposition:
- Package pp_reduce_pkg holds:
  - function csa_levels(n)
  - function rows_after(n, lvl)
  - localparam-style helper for CW
- Sub-module csa_row:
  - Parameter W.
  - Purely combinational: three W-bit rows in, sum and shifted-carry rows out.
  - Built from the existing fa cell.
  - Instantiated floor(n/3) times per level by a generate loop.

Test Plan:
- Basic latency, NUM_PP=4, WIDTH=16: rows 0x0001,0x0002,0x0003,0x0004 with in_valid for one cycle, out_ready=1 -> out_valid exactly 3 cycles later with sum=0x000A, then out_valid=0.
- Wrap-around: all rows 0xFFFF -> sum=0xFFFC; with PP_REDUCE_CARRY_OUT_EN, sum_hi=2'b11.
- Throughput: 20 back-to-back random operand sets with out_ready=1 -> 20 consecutive valid outputs matching the reference model in order, in_ready constantly 1.
- Backpressure: out_ready=0 for 5 cycles once the output is valid -> in_ready=0 during the stall, sum stable, no loss or duplication after out_ready returns to 1 (checked against a scoreboard).
- Reset mid-operation: rst_n asserted asynchronously mid-clock with 3 items in flight -> out_valid=0 and sum=0 immediately; after release, only new inputs emerge.
- Parameter sweep: NUM_PP=3 (LAT 2), NUM_PP=9 with WIDTH=32 (LAT 5), random rows -> latency and sums match the model.
